// File: rtl/gcbp_bram_ring_addr_gen_if.sv
// Signal bundle between GCBP line timing, the slot/address generator and the BRAM/correlator side.
// The master drives line/frame timing and correlator status; the slave returns slot indices, write strobes and status.
interface gcbp_bram_ring_addr_gen_if #(
  parameter int C_LINE_CNT_WIDTH = 10,
  parameter int C_ADDR_WIDTH     = 9,
  parameter int C_SLOT_W         = 2
);
  logic                        i_valid_subimage_line;
  logic [C_LINE_CNT_WIDTH-1:0] i_line_cnt;
  logic [C_LINE_CNT_WIDTH-1:0] i_subimage_start_line_num;
  logic                        i_new_line;
  logic                        i_new_frame;
  logic                        i_corr_busy;
  logic [C_SLOT_W-1:0]         o_next_slot;
  logic [C_SLOT_W-1:0]         o_curr_slot;
  logic [C_SLOT_W-1:0]         o_prev_slot;
  logic [C_ADDR_WIDTH-1:0]     o_write_addr;
  logic                        o_write_en;
  logic                        o_frame_ready;
  logic                        o_frame_dropped;
  logic [1:0]                  o_valid_frames;
  logic                        o_line_overflow;

  modport master (
    output i_valid_subimage_line, i_line_cnt, i_subimage_start_line_num,
           i_new_line, i_new_frame, i_corr_busy,
    input  o_next_slot, o_curr_slot, o_prev_slot, o_write_addr, o_write_en,
           o_frame_ready, o_frame_dropped, o_valid_frames, o_line_overflow
  );

  modport slave (
    input  i_valid_subimage_line, i_line_cnt, i_subimage_start_line_num,
           i_new_line, i_new_frame, i_corr_busy,
    output o_next_slot, o_curr_slot, o_prev_slot, o_write_addr, o_write_en,
           o_frame_ready, o_frame_dropped, o_valid_frames, o_line_overflow
  );
endinterface

// File: rtl/gcbp_bram_ring_addr_gen.sv
// Ring of C_NUM_SLOTS frame slots: rotates the write slot on complete frames while the correlator is idle,
// drops incomplete/blocked frames, and issues a registered BRAM write address per accepted subimage line.
module gcbp_bram_ring_addr_gen #(
  parameter int C_NUM_SLOTS          = 3,
  parameter int C_SLOT_OFFSET        = 128,
  parameter int C_LINES_PER_SUBIMAGE = 64,
  parameter int C_ADDR_WIDTH         = 9,
  parameter int C_LINE_CNT_WIDTH     = 10
) (
  input  logic                  i_clk,
  input  logic                  i_resetn,
  gcbp_bram_ring_addr_gen_if.slave bus
);
  localparam int C_SLOT_W = $clog2(C_NUM_SLOTS);
  localparam int C_CNT_W  = $clog2(C_LINES_PER_SUBIMAGE + 1);

  localparam logic [C_SLOT_W-1:0]       C_LAST_SLOT = C_SLOT_W'(C_NUM_SLOTS - 1);
  localparam logic [C_SLOT_W-1:0]       C_PREV_ADJ  = C_SLOT_W'(C_NUM_SLOTS - 2);
  localparam logic [C_CNT_W-1:0]        C_LINES_CNT = C_CNT_W'(C_LINES_PER_SUBIMAGE);
  localparam logic [C_LINE_CNT_WIDTH:0] C_LINES_EXT = (C_LINE_CNT_WIDTH + 1)'(C_LINES_PER_SUBIMAGE);
  localparam logic [C_ADDR_WIDTH-1:0]   C_OFFSET_A  = C_ADDR_WIDTH'(C_SLOT_OFFSET);

  logic [C_SLOT_W-1:0]         wp_q, wp_d;
  logic [C_CNT_W-1:0]          acc_cnt_q, acc_cnt_d;
  logic [C_ADDR_WIDTH-1:0]     write_addr_q, write_addr_d;
  logic                        write_en_q, write_en_d;
  logic                        frame_ready_q, frame_ready_d;
  logic                        frame_dropped_q, frame_dropped_d;
  logic [1:0]                  valid_frames_q, valid_frames_d;
  logic                        line_overflow_q, line_overflow_d;

  logic [C_LINE_CNT_WIDTH-1:0] diff;
  logic [C_CNT_W-1:0]          cnt_base;
  logic                        line_req, line_ok, frame_complete, rotate;

  // All o_* strobes are single-cycle pulses registered one cycle after the triggering input; no backpressure.
  always_comb begin
    diff            = bus.i_line_cnt - bus.i_subimage_start_line_num;
    line_req        = bus.i_new_line & bus.i_valid_subimage_line;
    line_ok         = line_req & ({1'b0, diff} < C_LINES_EXT);
    frame_complete  = (acc_cnt_q == C_LINES_CNT);
    rotate          = bus.i_new_frame & frame_complete & ~bus.i_corr_busy;

    wp_d            = wp_q;
    valid_frames_d  = valid_frames_q;
    if (rotate) begin
      wp_d = (wp_q == C_LAST_SLOT) ? '0 : wp_q + C_SLOT_W'(1);
      if (valid_frames_q != 2'd2) valid_frames_d = valid_frames_q + 2'd1;
    end

    // The frame boundary wins: a coincident line becomes line 1 of the new frame in the post-rotation slot.
    cnt_base        = bus.i_new_frame ? '0 : acc_cnt_q;
    acc_cnt_d       = cnt_base;
    if (line_ok && cnt_base != C_LINES_CNT) acc_cnt_d = cnt_base + C_CNT_W'(1);

    write_addr_d    = write_addr_q;
    if (line_ok) write_addr_d = C_ADDR_WIDTH'(wp_d) * C_OFFSET_A + C_ADDR_WIDTH'(diff);

    write_en_d      = line_ok;
    frame_ready_d   = rotate;
    frame_dropped_d = bus.i_new_frame & ~rotate;
    line_overflow_d = line_overflow_q | (line_req & ~line_ok);
  end

  always_ff @(posedge i_clk) begin
    if (i_resetn) begin
      wp_q            <= '0;
      acc_cnt_q       <= '0;
      write_addr_q    <= '0;
      write_en_q      <= 1'b0;
      frame_ready_q   <= 1'b0;
      frame_dropped_q <= 1'b0;
      valid_frames_q  <= 2'd0;
      line_overflow_q <= 1'b0;
    end else begin
      wp_q            <= wp_d;
      acc_cnt_q       <= acc_cnt_d;
      write_addr_q    <= write_addr_d;
      write_en_q      <= write_en_d;
      frame_ready_q   <= frame_ready_d;
      frame_dropped_q <= frame_dropped_d;
      valid_frames_q  <= valid_frames_d;
      line_overflow_q <= line_overflow_d;
    end
  end

  assign bus.o_next_slot     = wp_q;
  assign bus.o_curr_slot     = (wp_q == '0) ? C_LAST_SLOT : wp_q - C_SLOT_W'(1);
  assign bus.o_prev_slot     = (wp_q >= C_SLOT_W'(2)) ? wp_q - C_SLOT_W'(2) : wp_q + C_PREV_ADJ;
  assign bus.o_write_addr    = write_addr_q;
  assign bus.o_write_en      = write_en_q;
  assign bus.o_frame_ready   = frame_ready_q;
  assign bus.o_frame_dropped = frame_dropped_q;
  assign bus.o_valid_frames  = valid_frames_q;
  assign bus.o_line_overflow = line_overflow_q;
endmodule

// File: doc/gcbp_bram_ring_addr_gen.md
Name: gcbp_bram_ring_addr_gen

Overview:
Parametrised frame-slot manager and BRAM write-address generator for GCBP subimage storage. It rotates C_NUM_SLOTS frame slots as a ring: one slot is being written (next), one is current and one is previous. Unlike the fixed three-slot decoder, it holds rotation while the correlator is busy and drops incomplete or blocked frames. It also validates line offsets and reports frame completion, drops and overflow. It sits between the GCBP encoder line timing and the BRAM array / correlator.

Parameters:
C_NUM_SLOTS, 3, number of frame slots in BRAM; must be >= 3
C_SLOT_OFFSET, 128, word distance between slot base addresses
C_LINES_PER_SUBIMAGE, 64, lines (words) per subimage; power of two
C_ADDR_WIDTH, 9, BRAM word-address width; C_NUM_SLOTS*C_SLOT_OFFSET <= 2^C_ADDR_WIDTH
C_LINE_CNT_WIDTH, 10, width of line counters
C_SLOT_W, clog2(C_NUM_SLOTS), derived slot index width (localparam)

Ports:
i_clk  in  1  system clock
i_resetn  in  1  synchronous, active-high reset (asserted = 1 resets)
i_valid_subimage_line  in  1  current line lies inside the subimage vertical window
i_line_cnt  in  C_LINE_CNT_WIDTH  current frame line number
i_subimage_start_line_num  in  C_LINE_CNT_WIDTH  first line of subimage
i_new_line  in  1  one-cycle pulse, start of line
i_new_frame  in  1  one-cycle pulse, start of frame
i_corr_busy  in  1  correlator is reading prev/curr slots; rotation forbidden
o_next_slot  out  C_SLOT_W  slot being written
o_curr_slot  out  C_SLOT_W  current-frame slot
o_prev_slot  out  C_SLOT_W  previous-frame slot
o_write_addr  out  C_ADDR_WIDTH  registered BRAM write address
o_write_en  out  1  one-cycle write strobe for an accepted line
o_frame_ready  out  1  one-cycle pulse: rotation done, new curr valid
o_frame_dropped  out  1  one-cycle pulse: written frame discarded
o_valid_frames  out  2  number of valid frames in curr/prev (saturates at 2)
o_line_overflow  out  1  sticky: line offset out of range seen

Behaviour:
- Write pointer wp (C_SLOT_W bits). o_next_slot=wp, o_curr_slot=(wp-1) mod N, o_prev_slot=(wp-2) mod N; combinational from wp.
- Reset: wp=0, so next=0, curr=N-1, prev=N-2. Line offset=0, accepted-line counter=0, o_write_addr=0, o_valid_frames=0, all pulses=0, o_line_overflow=0.
- Line acceptance: when i_new_line & i_valid_subimage_line, compute diff=i_line_cnt-i_subimage_start_line_num (C_LINE_CNT_WIDTH bits, unsigned).
  - If diff < C_LINES_PER_SUBIMAGE: offset<=diff, accepted counter increments (saturates at C_LINES_PER_SUBIMAGE), and the next cycle drives o_write_en=1 and o_write_addr=o_next_slot*C_SLOT_OFFSET+offset (registered, latency 1).
  - Otherwise: no write, no count, o_line_overflow<=1 (cleared only by reset).
- Frame boundary on i_new_frame:
  - frame complete = accepted counter == C_LINES_PER_SUBIMAGE.
  - If complete & !i_corr_busy: wp<=(wp+1) mod N, wrapping N-1 -> 0. o_frame_ready pulses the next cycle; o_valid_frames increments, saturating at 2.
  - Else: wp is held, the slot is rewritten by the next frame, and o_frame_dropped pulses the next cycle. o_valid_frames is unchanged.
  - In both cases the accepted counter is cleared.
- Simultaneous i_new_frame and accepted i_new_line: the frame boundary is evaluated first, using the counter before this line. The line then counts as line 1 of the new frame (counter=1) and is written to the post-rotation slot.
- i_corr_busy is sampled only on the i_new_frame cycle.
- No outputs depend on i_new_line when i_valid_subimage_line=0.
- Reset mid-frame: all state returns to reset values on the next edge; any pending o_write_en/pulse is suppressed.
- Address arithmetic: the product is computed at C_ADDR_WIDTH bits; the parameter constraint guarantees no overflow.

Test Plan:
- Reset with defaults -> next=0, curr=2, prev=1, o_write_addr=0, o_valid_frames=0, all strobes 0.
- start=100; new_line with line_cnt=100..163, then new_frame with busy=0 -> 64 o_write_en pulses at addresses 0..63; then o_frame_ready, next=1, curr=0, prev=2, o_valid_frames=1.
- Four complete frames, busy=0 -> wp sequence 0,1,2,0,1; o_valid_frames=2 (saturated); the second frame writes addresses 128..191 and the third 256..319.
- Complete frame, new_frame with i_corr_busy=1 -> o_frame_dropped pulse, wp stays 0, next frame rewrites addresses 0..63.
- Only 40 lines accepted, then new_frame -> o_frame_dropped, no rotation. A line with line_cnt=start+64 -> no write, o_line_overflow=1 and held until reset.
- new_frame coincident with new_line at line_cnt=start after a complete frame -> rotation to wp=1; o_write_en with o_write_addr=128; counter=1. Reset asserted mid-frame -> reset values next cycle.
